// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg
// Shared types and helpers for the round-robin adder scheduler.
//   NREQ_P / WIDTH_P / LAT_P : default requester count, operand width and
//                              adder pipeline depth used by the scheduler.
//   op_t   : operation record entering the adder {valid, id, a, b, cin}
//   res_t  : result record leaving the adder {valid, id, sum, cout}
//   rr_grant() : rotated-priority one-hot grant from (valid, last_grant)
// The record widths follow NREQ_P/WIDTH_P, so a different requester count or
// operand width is selected here rather than by overriding module parameters.
package adder_sched_pkg;

  localparam int NREQ_P  = 4;
  localparam int WIDTH_P = 16;
  localparam int LAT_P   = 2;
  localparam int IDW_P   = $clog2(NREQ_P);

  typedef struct packed {
    logic               valid;
    logic [IDW_P-1:0]   id;
    logic [WIDTH_P-1:0] a;
    logic [WIDTH_P-1:0] b;
    logic               cin;
  } op_t;

  typedef struct packed {
    logic               valid;
    logic [IDW_P-1:0]   id;
    logic [WIDTH_P-1:0] sum;
    logic               cout;
  } res_t;

  // Search starts just after the last granted requester and wraps, so the
  // most recently served requester has the lowest priority.
  function automatic logic [NREQ_P-1:0] rr_grant(input logic [NREQ_P-1:0] valid,
                                                 input logic [IDW_P-1:0]  last);
    logic [NREQ_P-1:0] g;
    int idx;
    g = '0;
    for (int k = 1; k <= NREQ_P; k++) begin
      idx = (int'(last) + k) % NREQ_P;
      if (valid[idx] && (g == '0)) begin
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_add_pipe.sv
// add_pipe
// LAT-stage pipelined adder with a common stall enable. The add happens on
// entry to stage 0; later stages only carry the {valid, id, sum, cout} tag.
//   clk     : clock
//   rst     : synchronous active-high reset, clears every stage
//   en      : shift enable; when low every stage holds
//   in_op   : operation offered to stage 0 (valid=0 inserts a bubble)
//   out_res : contents of the last stage
//   busy    : any stage holds a valid operation
module add_pipe
  import adder_sched_pkg::*;
#(
  parameter int LAT = LAT_P
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  op_t  in_op,
  output res_t out_res,
  output logic busy
);

  res_t             stage_reg [LAT];
  logic [WIDTH_P:0] full_sum;
  logic [LAT-1:0]   stage_valid;

  // Operands are zero-extended so the carry is taken from the full-width sum.
  assign full_sum = {1'b0, in_op.a} + {1'b0, in_op.b} + {{WIDTH_P{1'b0}}, in_op.cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (en) begin
      stage_reg[0] <= '{valid: in_op.valid, id: in_op.id,
                        sum: full_sum[WIDTH_P-1:0], cout: full_sum[WIDTH_P]};
      for (int i = 1; i < LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < LAT; gi++) begin : g_valid
    assign stage_valid[gi] = stage_reg[gi].valid;
  end

  assign busy    = |stage_valid;
  assign out_res = stage_reg[LAT-1];

endmodule

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Round-robin arbiter sharing one pipelined adder among NREQ requesters.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin           : per-requester carry-in
//   rsp_valid/ready   : response handshake with backpressure
//   rsp_id/sum/cout   : requester index, (a+b+cin) mod 2^WIDTH, carry out
//   busy              : any adder stage holds a valid operation
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int NREQ  = NREQ_P,
  parameter  int WIDTH = WIDTH_P,
  parameter  int LAT   = LAT_P,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  logic             advance;
  logic [IDW-1:0]   last_grant_reg;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  op_t              in_op;
  res_t             out_res;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // The pipeline only moves when the last stage is empty or being drained.
  assign advance = !(rsp_valid && !rsp_ready);

  // Granting is suppressed during reset and while stalled, so every grant is
  // also an accept and enters the pipeline in the same cycle.
  always_comb begin
    grant = '0;
    if (!rst && advance) begin
      grant = rr_grant(req_valid, last_grant_reg);
    end
  end

  assign req_ready = grant;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id = IDW'(i);
      end
    end
  end

  always_comb begin
    in_op       = '0;
    in_op.valid = |grant;
    in_op.id    = grant_id;
    in_op.a     = a_arr[grant_id];
    in_op.b     = b_arr[grant_id];
    in_op.cin   = req_cin[grant_id];
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= IDW'(NREQ - 1);
    end else if (|grant) begin
      last_grant_reg <= grant_id;
    end
  end

  add_pipe #(
    .LAT (LAT)
  ) u_add_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (advance),
    .in_op   (in_op),
    .out_res (out_res),
    .busy    (busy)
  );

  assign rsp_valid = out_res.valid;
  assign rsp_id    = out_res.id;
  assign rsp_sum   = out_res.sum;
  assign rsp_cout  = out_res.cout;

endmodule
